// File: rtl/lbp_pkg.sv
// lbp_pkg: shared FSM states, LBP neighbour bit positions and address-width helper for the LBP engine.
package lbp_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD9, S_SHIFT3, S_CALC, S_OUT, S_BORDER, S_DONE} state_t;
  localparam int BIT_TL = 0;
  localparam int BIT_T  = 1;
  localparam int BIT_TR = 2;
  localparam int BIT_L  = 3;
  localparam int BIT_R  = 4;
  localparam int BIT_BL = 5;
  localparam int BIT_B  = 6;
  localparam int BIT_BR = 7;
  function automatic int lbp_aw(input int w, input int h);
    return $clog2(w * h);
  endfunction
endpackage

// File: rtl/lbp_window.sv
// lbp_window: 3x3 pixel window with single-cell load and left shift, plus the
// combinational LBP compare of each neighbour against center+THRESH (no wrap).
module lbp_window import lbp_pkg::*; #(
  parameter int PIX_W  = 8,
  parameter int THRESH = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_ld,
  input  logic [1:0]       i_ld_row,
  input  logic [1:0]       i_ld_col,
  input  logic             i_shift,
  input  logic [PIX_W-1:0] i_data,
  output logic [7:0]       o_code
);
  logic [PIX_W-1:0] r_win [3][3];
  logic [PIX_W-1:0] w_nb [8];
  logic [PIX_W:0]   w_ctr;
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) r_win[r][c] <= '0;
    else if (i_shift)
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
    else if (i_ld) r_win[i_ld_row][i_ld_col] <= i_data;
  always_comb begin
    w_nb[BIT_TL] = r_win[0][0];
    w_nb[BIT_T]  = r_win[0][1];
    w_nb[BIT_TR] = r_win[0][2];
    w_nb[BIT_L]  = r_win[1][0];
    w_nb[BIT_R]  = r_win[1][2];
    w_nb[BIT_BL] = r_win[2][0];
    w_nb[BIT_B]  = r_win[2][1];
    w_nb[BIT_BR] = r_win[2][2];
    w_ctr = {1'b0, r_win[1][1]} + (PIX_W+1)'(THRESH);
    for (int i = 0; i < 8; i++) o_code[i] = {1'b0, w_nb[i]} >= w_ctr;
  end
endmodule

// File: rtl/lbp_engine.sv
// lbp_engine: raster-order 3x3 LBP engine with memory read port and valid/ready result port.
// Define LBP_BORDER_EN to also emit 8'h00 for every border pixel (full-frame ascending output).
module lbp_engine import lbp_pkg::*; #(
  parameter  int IMG_W  = 128,
  parameter  int IMG_H  = 128,
  parameter  int PIX_W  = 8,
  parameter  int THRESH = 0,
  localparam int AW     = lbp_aw(IMG_W, IMG_H)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             gray_ready,
  output logic             gray_req,
  output logic [AW-1:0]    gray_addr,
  input  logic [PIX_W-1:0] gray_data,
  output logic             lbp_valid,
  input  logic             lbp_ready,
  output logic [AW-1:0]    lbp_addr,
  output logic [7:0]       lbp_data,
  output logic             busy,
  output logic             finish
);
  state_t        r_state;
  logic [3:0]    r_cnt, r_cap_n;
  logic          r_cap;
  logic [AW-1:0] r_caddr, r_row, r_col;
  logic [1:0]    w_rsel, w_csel, w_lrow, w_lcol;
  logic [AW-1:0] w_raddr;
  logic [7:0]    w_code;
  logic          w_more, w_shift;
`ifdef LBP_BORDER_EN
  logic          r_fin;
`endif
  // read n of a window is at row n%3, col n/3 relative to the top-left corner
  always_comb begin
    w_rsel  = 2'(r_cnt % 4'd3);
    w_csel  = 2'(r_cnt / 4'd3);
    w_lrow  = 2'(r_cap_n % 4'd3);
    w_lcol  = 2'(r_cap_n / 4'd3);
    w_raddr = r_caddr - AW'(IMG_W + 1) + AW'(w_csel)
            + (w_rsel == 2'd2 ? AW'(2 * IMG_W) : w_rsel == 2'd1 ? AW'(IMG_W) : '0);
    w_more  = r_col != AW'(IMG_W - 2);
    w_shift = r_state == S_OUT && lbp_ready && w_more;
  end
  lbp_window #(.PIX_W(PIX_W), .THRESH(THRESH)) u_win (
    .clk(clk), .reset(reset), .i_ld(r_cap), .i_ld_row(w_lrow), .i_ld_col(w_lcol),
    .i_shift(w_shift), .i_data(gray_data), .o_code(w_code)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cap_n   <= '0;
      r_cap     <= 1'b0;
      r_caddr   <= '0;
      r_row     <= '0;
      r_col     <= '0;
      gray_req  <= 1'b0;
      gray_addr <= '0;
      lbp_valid <= 1'b0;
      lbp_addr  <= '0;
      lbp_data  <= '0;
      busy      <= 1'b0;
      finish    <= 1'b0;
`ifdef LBP_BORDER_EN
      r_fin     <= 1'b0;
`endif
    end else begin
      finish <= 1'b0;
      case (r_state)
        S_IDLE: if (start && gray_ready) begin
          busy    <= 1'b1;
          r_row   <= AW'(1);
          r_col   <= AW'(1);
          r_caddr <= AW'(IMG_W + 1);
`ifdef LBP_BORDER_EN
          r_fin     <= 1'b0;
          lbp_valid <= 1'b1;
          lbp_data  <= '0;
          lbp_addr  <= '0;
          r_state   <= S_BORDER;
`else
          r_cnt   <= '0;
          r_state <= S_LOAD9;
`endif
        end
        S_LOAD9, S_SHIFT3: begin
          if (r_cnt != 4'd9) begin
            gray_req  <= 1'b1;
            gray_addr <= w_raddr;
            r_cap     <= 1'b1;
            r_cap_n   <= r_cnt;
            r_cnt     <= r_cnt + 4'd1;
          end else begin
            gray_req <= 1'b0;
            r_cap    <= 1'b0;
          end
          if (r_cap && r_cap_n == 4'd8) r_state <= S_CALC;
        end
        S_CALC: begin
          lbp_valid <= 1'b1;
          lbp_data  <= w_code;
          lbp_addr  <= r_caddr;
          r_state   <= S_OUT;
        end
        S_OUT: if (lbp_ready) begin
          if (w_more) begin
            r_col     <= r_col + 1'b1;
            r_caddr   <= r_caddr + 1'b1;
            r_cnt     <= 4'd6;
            lbp_valid <= 1'b0;
            r_state   <= S_SHIFT3;
          end else begin
            if (r_row != AW'(IMG_H - 2)) begin
              r_row   <= r_row + 1'b1;
              r_col   <= AW'(1);
              r_caddr <= r_caddr + AW'(3);
            end
`ifdef LBP_BORDER_EN
            else r_fin <= 1'b1;
            lbp_addr <= lbp_addr + 1'b1;
            lbp_data <= '0;
            r_state  <= S_BORDER;
`else
            lbp_valid <= 1'b0;
            if (r_row != AW'(IMG_H - 2)) begin
              r_cnt   <= '0;
              r_state <= S_LOAD9;
            end else begin
              finish  <= 1'b1;
              busy    <= 1'b0;
              r_state <= S_DONE;
            end
`endif
          end
        end
`ifdef LBP_BORDER_EN
        S_BORDER: if (lbp_ready) begin
          if (lbp_addr == AW'(IMG_W * IMG_H - 1)) begin
            lbp_valid <= 1'b0;
            finish    <= 1'b1;
            busy      <= 1'b0;
            r_state   <= S_DONE;
          end else if (!r_fin && lbp_addr + 1'b1 == r_caddr) begin
            lbp_valid <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_LOAD9;
          end else lbp_addr <= lbp_addr + 1'b1;
        end
`endif
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_lbp_engine.sv
// tb_lbp_engine: directed checks of a 5x5 THRESH=0 engine and a 3x3 THRESH=10 engine.
module tb_lbp_engine;
  logic clk = 1'b0;
  logic reset, start, gray_ready, lbp_ready;
  logic gray_req, lbp_valid, busy, finish;
  logic [4:0] gray_addr, lbp_addr;
  logic [7:0] gray_data, lbp_data;
  logic [7:0] mem [0:31];
  logic b_start, b_req, b_valid, b_busy, b_finish;
  logic [3:0] b_gaddr, b_laddr;
  logic [7:0] b_gdata, b_ldata;
  logic [7:0] mb [0:15];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  assign gray_data = mem[gray_addr];
  assign b_gdata = mb[b_gaddr];
  lbp_engine #(.IMG_W(5), .IMG_H(5), .PIX_W(8), .THRESH(0)) dut (
    .clk(clk), .reset(reset), .start(start), .gray_ready(gray_ready), .gray_req(gray_req),
    .gray_addr(gray_addr), .gray_data(gray_data), .lbp_valid(lbp_valid), .lbp_ready(lbp_ready),
    .lbp_addr(lbp_addr), .lbp_data(lbp_data), .busy(busy), .finish(finish));
  lbp_engine #(.IMG_W(3), .IMG_H(3), .PIX_W(8), .THRESH(10)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .gray_ready(1'b1), .gray_req(b_req),
    .gray_addr(b_gaddr), .gray_data(b_gdata), .lbp_valid(b_valid), .lbp_ready(1'b1),
    .lbp_addr(b_laddr), .lbp_data(b_ldata), .busy(b_busy), .finish(b_finish));

  task automatic check_reset_outputs(input string nm);
    int v [7];
    string s [7];
    v = '{int'(gray_req), int'(gray_addr), int'(lbp_valid), int'(lbp_addr), int'(lbp_data), int'(busy), int'(finish)};
    s = '{"gray_req", "gray_addr", "lbp_valid", "lbp_addr", "lbp_data", "busy", "finish"};
    for (int i = 0; i < 7; i++) begin
      total++;
      if (v[i] !== 0) begin bad++; $display("FAIL %s_%s got %0d want 0", nm, s[i], v[i]); end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    gray_ready = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || gray_req !== 1'b0) begin
      bad++; $display("FAIL gray_not_ready busy=%b req=%b want 0 0", busy, gray_req);
    end
    gray_ready = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] code, input bit rnd, input bit hold, input string nm);
    logic [4:0] ea [$];
    logic [7:0] ed [$];
    int n = 0, fin = 0, cyc = 0, serr = 0, ierr = 0, t1 = -1, t2 = -1;
    logic pv = 1'b0, pr = 1'b0;
    logic [4:0] pa = '0;
    logic [7:0] pd = '0;
    for (int a = 0; a < 25; a++) begin
      bit inr;
      inr = a / 5 >= 1 && a / 5 <= 3 && a % 5 >= 1 && a % 5 <= 3;
`ifdef LBP_BORDER_EN
      ea.push_back(5'(a)); ed.push_back(inr ? code : 8'h00);
`else
      if (inr) begin ea.push_back(5'(a)); ed.push_back(code); end
`endif
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) if (!hold) start = 1'b0;
    while (fin == 0 && cyc < 3000) begin
      lbp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (finish) begin fin++; start = 1'b0; end
      if (lbp_valid && gray_req) serr++;
      if (pv && !pr && (!lbp_valid || lbp_addr !== pa || lbp_data !== pd)) serr++;
      if (lbp_valid && lbp_ready) begin
        if (n == 0) t1 = cyc;
        if (n == 1) t2 = cyc;
        if (n < ea.size()) begin
          total += 2;
          if (lbp_addr !== ea[n]) begin bad++; $display("FAIL %s_addr[%0d] got %0d want %0d", nm, n, lbp_addr, ea[n]); end
          if (lbp_data !== ed[n]) begin bad++; $display("FAIL %s_data[%0d] got %h want %h", nm, n, lbp_data, ed[n]); end
        end else begin
          total++; bad++; $display("FAIL %s_extra got addr %0d want no transfer", nm, lbp_addr);
        end
        n++;
      end
      pv = lbp_valid; pr = lbp_ready; pa = lbp_addr; pd = lbp_data;
      @(negedge clk) cyc++;
    end
    start = 1'b0;
    lbp_ready = 1'b1;
    repeat (4) begin
      if (finish) fin++;
      if (busy || gray_req || lbp_valid) ierr++;
      @(negedge clk);
    end
    total += 4;
    if (n != ea.size()) begin bad++; $display("FAIL %s_count got %0d want %0d", nm, n, ea.size()); end
    if (fin != 1) begin bad++; $display("FAIL %s_finish got %0d pulses want 1", nm, fin); end
    if (serr != 0) begin bad++; $display("FAIL %s_stall got %0d violations want 0", nm, serr); end
    if (ierr != 0) begin bad++; $display("FAIL %s_idle got %0d active cycles want 0", nm, ierr); end
`ifndef LBP_BORDER_EN
    if (!rnd && !hold) begin
      total += 2;
      if (t1 != 11) begin bad++; $display("FAIL %s_first_latency got %0d want 11", nm, t1); end
      if (t2 != 17) begin bad++; $display("FAIL %s_inrow_latency got %0d want 17", nm, t2); end
    end
`endif
  endtask

  task automatic fill_ramp;
    for (int i = 0; i < 25; i++) mem[i] = 8'(i);
  endtask

  task automatic test_flat;
    for (int i = 0; i < 25; i++) mem[i] = 8'd50;
    run_frame(8'hFF, 1'b0, 1'b0, "flat");
  endtask

  task automatic test_ramp;
    fill_ramp();
    run_frame(8'hF0, 1'b0, 1'b0, "ramp");
  endtask

  task automatic test_backpressure;
    fill_ramp();
    run_frame(8'hF0, 1'b1, 1'b0, "bp");
  endtask

  task automatic test_back_to_back;
    fill_ramp();
    run_frame(8'hF0, 1'b0, 1'b1, "hold_start");
  endtask

  task automatic test_reset_midframe;
    int n = 0, cyc = 0;
    fill_ramp();
    lbp_ready = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (cyc < 500) begin
      if (lbp_valid) begin
        if (n == 2) break;
        n++;
      end
      @(negedge clk) cyc++;
    end
    total++;
    if (cyc >= 500) begin bad++; $display("FAIL midframe_timeout got %0d outputs want 3", n); end
    reset = 1'b1;
    #1 check_reset_outputs("midframe");
    @(negedge clk) reset = 1'b0;
    run_frame(8'hF0, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic run_b(input logic [7:0] code, input string nm);
    int nb = 0, cyc = 0;
    logic [7:0] got = 'x;
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    while (!b_finish && cyc < 500) begin
      if (b_valid) begin
        nb++;
        if (b_laddr == 4'd4) got = b_ldata;
      end
      @(negedge clk) cyc++;
    end
    total += 2;
    if (got !== code) begin bad++; $display("FAIL %s_code got %h want %h", nm, got, code); end
`ifdef LBP_BORDER_EN
    if (nb != 9) begin bad++; $display("FAIL %s_count got %0d want 9", nm, nb); end
`else
    if (nb != 1) begin bad++; $display("FAIL %s_count got %0d want 1", nm, nb); end
`endif
    repeat (2) @(negedge clk);
  endtask

  task automatic test_thresh;
    for (int i = 0; i < 9; i++) mb[i] = 8'd255;
    mb[4] = 8'd250;
    run_b(8'h00, "thresh_nowrap");
    mb[0] = 8'd15; mb[1] = 8'd14; mb[2] = 8'd255;
    mb[3] = 8'd0;  mb[4] = 8'd5;  mb[5] = 8'd16;
    mb[6] = 8'd15; mb[7] = 8'd14; mb[8] = 8'd200;
    run_b(8'hB5, "thresh_tie");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; gray_ready = 1'b1; lbp_ready = 1'b0; b_start = 1'b0;
    test_reset();
    test_flat();
    test_ramp();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    test_thresh();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
